// File: rtl/line_mem_arbiter.sv
// Arbitrates icache and dcache line requests onto a single burst memory port.
// The dcache has fixed priority over the icache. Each line moves as BEATS beats of BEAT_W bits.
module line_mem_arbiter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_read,
    input  logic [31:0]             i_addr,
    output logic [BEATS*BEAT_W-1:0] i_rdata,
    output logic                    i_resp,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [31:0]             d_addr,
    input  logic [BEATS*BEAT_W-1:0] d_wdata,
    output logic [BEATS*BEAT_W-1:0] d_rdata,
    output logic                    d_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [31:0]             pmem_address,
    output logic [BEAT_W-1:0]       pmem_wdata,
    input  logic [BEAT_W-1:0]       pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int                LINE_W     = BEATS * BEAT_W;
    localparam int                CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BEATS - 1);
    localparam logic [31:0]       ALIGN_MASK = ~32'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t            state_r;
    grant_t            grant_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       addr_r;
    logic [LINE_W-1:0] line_r;
    logic              pmem_read_r;
    logic              pmem_write_r;
    logic [BEAT_W-1:0] pmem_wdata_r;
    logic              i_resp_r;
    logic              d_resp_r;

    state_t            win_state_s;
    logic [31:0]       win_addr_s;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    function automatic logic [BEAT_W-1:0] beat_of(input logic [LINE_W-1:0] line, input int idx);
        return line[idx*BEAT_W +: BEAT_W];
    endfunction

    // Fixed-priority pick among pending requests: write-back, then dcache read, then icache read.
    always_comb begin
        win_state_s = IDLE;
        win_addr_s  = 32'd0;
        if (d_write) begin
            win_state_s = D_WR;
            win_addr_s  = d_addr;
        end else if (d_read) begin
            win_state_s = D_RD;
            win_addr_s  = d_addr;
        end else if (i_read) begin
            win_state_s = I_RD;
            win_addr_s  = i_addr;
        end else begin
            win_state_s = IDLE;
            win_addr_s  = 32'd0;
        end
    end

    // Burst sequencer; every memory-side and response output is a register set here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            grant_r      <= GRANT_I;
            cnt_r        <= '0;
            addr_r       <= 32'd0;
            line_r       <= '0;
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
            pmem_wdata_r <= '0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    i_resp_r <= 1'b0;
                    d_resp_r <= 1'b0;
                    if (win_state_s != IDLE) begin
                        state_r      <= win_state_s;
                        addr_r       <= line_align(win_addr_s);
                        grant_r      <= (win_state_s == I_RD) ? GRANT_I : GRANT_D;
                        cnt_r        <= '0;
                        pmem_read_r  <= (win_state_s != D_WR);
                        pmem_write_r <= (win_state_s == D_WR);
                        pmem_wdata_r <= (win_state_s == D_WR) ? beat_of(d_wdata, 0) : '0;
                    end
                end
                I_RD, D_RD: begin
                    if (pmem_resp) begin
                        line_r[int'(cnt_r)*BEAT_W +: BEAT_W] <= pmem_rdata;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_r     <= DONE;
                            pmem_read_r <= 1'b0;
                            i_resp_r    <= (grant_r == GRANT_I);
                            d_resp_r    <= (grant_r == GRANT_D);
                        end
                    end
                end
                D_WR: begin
                    if (pmem_resp) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_r      <= DONE;
                            pmem_write_r <= 1'b0;
                            pmem_wdata_r <= '0;
                            d_resp_r     <= 1'b1;
                        end else begin
                            // present the next beat only once the current one is accepted
                            pmem_wdata_r <= beat_of(d_wdata, int'(cnt_r) + 1);
                        end
                    end
                end
                DONE: begin
                    // one bubble cycle lets the requester drop its request before IDLE looks again
                    state_r  <= IDLE;
                    i_resp_r <= 1'b0;
                    d_resp_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= '0;
                    pmem_read_r  <= 1'b0;
                    pmem_write_r <= 1'b0;
                    pmem_wdata_r <= '0;
                    i_resp_r     <= 1'b0;
                    d_resp_r     <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = addr_r;
    assign pmem_wdata   = pmem_wdata_r;
    assign i_resp       = i_resp_r;
    assign d_resp       = d_resp_r;
    assign i_rdata      = line_r;
    assign d_rdata      = line_r;

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Arbitrates cache-line requests from the instruction cache and the data cache, which sit behind the pipelined datapath's `imem_*` and `dmem_*` ports, onto a single burst-based physical memory port. Each 256-bit line transfer is split into four 64-bit beats. The block sits directly downstream of the caches and is the only master of physical memory. The data cache has fixed priority, because its request belongs to the older instruction in MEM.

## Interface
Parameters
- `BEATS`, 4: beats per line.
- `BEAT_W`, 64: bits per beat. Line width is `BEATS*BEAT_W` = 256.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `i_read`  in  1  icache line read request; held until `i_resp`.
- `i_addr`  in  32  icache line address.
- `i_rdata`  out  256  line returned to icache; valid only while `i_resp`=1.
- `i_resp`  out  1  one-cycle completion pulse to icache.
- `d_read`  in  1  dcache line read request; held until `d_resp`.
- `d_write`  in  1  dcache line write-back request; held until `d_resp`.
- `d_addr`  in  32  dcache line address.
- `d_wdata`  in  256  line to write; held stable while `d_write`=1.
- `d_rdata`  out  256  line returned to dcache; valid only while `d_resp`=1.
- `d_resp`  out  1  one-cycle completion pulse to dcache.
- `pmem_read`  out  1  physical memory burst read.
- `pmem_write`  out  1  physical memory burst write.
- `pmem_address`  out  32  burst base address, `{addr[31:5],5'b0}`.
- `pmem_wdata`  out  64  current write beat.
- `pmem_rdata`  in  64  current read beat.
- `pmem_resp`  in  1  beat accepted or beat data valid.

## Operation
- FSM states are IDLE, I_RD, D_RD, D_WR and DONE.
- IDLE arbitration, evaluated each cycle, first match wins:
  - `d_write` goes to D_WR.
  - `d_read` goes to D_RD.
  - `i_read` goes to I_RD.
  - Otherwise stay in IDLE.
- `d_write` and `d_read` both high is illegal. Write wins.
- On leaving IDLE:
  - Latch the line-aligned address into `addr_q`.
  - Latch the winner into `grant_q`.
  - Clear the beat counter `cnt` (2 bits).
- I_RD and D_RD:
  - `pmem_read`=1 and `pmem_address`=`addr_q`.
  - Each cycle with `pmem_resp`=1, write `pmem_rdata` into `line_q[64*cnt +: 64]` and increment `cnt`.
  - On the beat with `cnt`=3, go to DONE.
- D_WR:
  - `pmem_write`=1 and `pmem_wdata`=`d_wdata[64*cnt +: 64]`.
  - Increment `cnt` on each `pmem_resp`.
  - On the beat with `cnt`=3, go to DONE.
- DONE:
  - Assert the granted requester's `*_resp` for exactly one cycle, then go to IDLE.
  - `pmem_read`=`pmem_write`=0.
  - `i_rdata`=`d_rdata`=`line_q` combinationally; contents are undefined outside `*_resp`.
- The non-granted requester waits. Its request is never dropped and never double-serviced.
- `pmem_resp` arriving in IDLE or DONE is ignored.
- `cnt` wraps from 3 to 0 only on the state exit. No partial-line responses exist.
- Reset (`rst`=0, synchronous):
  - State goes to IDLE; `cnt`=0; `line_q`=0; `grant_q`=icache.
  - All outputs are 0, including `pmem_address`=0 and `pmem_wdata`=0.
- Reset mid-burst abandons the transfer. No `*_resp` is issued, and physical memory must tolerate the aborted burst.

## Timing
- Request sampled high in IDLE at edge E0. `pmem_read` or `pmem_write` is high from the cycle after E0.
- With `pmem_resp` high every cycle, beats complete at E1 to E4. `*_resp` is high in the cycle after E4 (DONE).
- Zero-wait latency from the request's first high cycle to `*_resp` is 6 cycles. Each memory stall adds 1 cycle.
- DONE forces one bubble cycle, so a requester drops its request on seeing `*_resp` before IDLE re-samples it.
- Back-to-back service: the next request is accepted at the edge leaving the IDLE cycle that follows DONE.
- `pmem_address` and `pmem_write` or `pmem_read` are stable for the whole burst. `pmem_wdata` changes only after a `pmem_resp` edge.
- All outputs are registered state or decode of registered state. There is no combinational path from `pmem_resp` to `pmem_read`, `pmem_write` or `pmem_address`.

## Test plan
- **Icache read, zero wait.**
  - Stimulus: `i_read`=1, `i_addr`=0x0000_0064; memory beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: `pmem_address`=0x0000_0060; `i_resp` is a single-cycle pulse 6 cycles after the request; `i_rdata`=`{0x44..44,0x33..33,0x22..22,0x11..11}`.
- **Dcache write-back with stalls.**
  - Stimulus: `d_write`=1, `d_addr`=0x8000_0020; `d_wdata` beats A, B, C, D; `pmem_resp` asserted only every other cycle.
  - Required: `pmem_wdata` sequence A, B, C, D, each held until its resp; `d_resp` arrives 10 cycles after the request.
- **Simultaneous requests.**
  - Stimulus: `i_read`=1 and `d_read`=1 in the same cycle.
  - Required: the dcache is serviced first; `i_resp` never pulses during the dcache burst; the icache burst starts 1 cycle after `d_resp`; each resp pulses exactly once.
- **Illegal `d_read` with `d_write`.**
  - Stimulus: both high together.
  - Required: a write burst only, with `pmem_read`=0 throughout.
- **Reset mid-burst.**
  - Stimulus: `rst`=0 after beat 2 of an icache read.
  - Required: in the next cycle all outputs are 0 and the state is IDLE; no `i_resp`. A reissued read completes normally with fresh data.
- **Spurious `pmem_resp` in IDLE.**
  - Stimulus: `pmem_resp` asserted while idle.
  - Required: no state change; a following read still captures beat 0 into `line_q[63:0]`.
